uart_tx_drain: RTL and testbench

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

---
 rtl/uart_pkg.sv | 16 +
 rtl/baud_tick_gen.sv | 29 ++
 rtl/uart_tx_drain.sv | 130 +++++++++++++
 tb/tb_uart_tx_drain.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit drain.
// Optional feature macro: UART_TX_PARITY_EN adds the even-parity bit state.
package uart_pkg;

    // FSM state encoding; the value 3 only exists when parity is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and wraps.
// tick is high on the last clock of every bit period.
module baud_tick_gen #(
    parameter int BAUD_DIV = 10416
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(BAUD_DIV - 1));

    // Free-running bit timer, held at zero by reset or clear, wraps on tick.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter draining a show-ahead FIFO: one word per frame,
// start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit.
// Handshake: fifo_rd is a one-cycle pop strobe, raised only in IDLE while
// fifo_empty=0 and reset is released; fifo_rdata is captured on that same
// edge, so the word at the FIFO head is consumed exactly once.
// The FSM state is kept in the typed signal 'state' for checker binding.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 10416
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_t           state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_shifted;
    logic [IDX_W-1:0]      bit_idx;
    logic                  tick;
    logic                  timer_clear;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit;
`endif

    // The bit timer restarts from zero whenever a frame is not in progress.
    assign timer_clear   = (state == IDLE);
    assign shreg_shifted = shreg >> 1;

    // Pop is combinational so it falls in the IDLE cycle itself, never while in reset.
    assign fifo_rd = reset && (state == IDLE) && !fifo_empty;

    // Last clock of the stop bit, decoded from registered state and timer.
    assign tx_done = (state == STOP) && tick;

    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (tick)
    );

    // Frame sequencer: tx and tx_busy are updated together with the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    bit_idx <= '0;
                    if (!fifo_empty) begin
                        shreg   <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_rdata;
`endif
                        state   <= START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shreg   <= shreg_shifted;
                            tx      <= shreg_shifted[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state   <= IDLE;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain with BAUD_DIV=4: an environment FIFO queue feeds
// the DUT, and a frame-level reference model predicts fifo_rd, tx, tx_busy
// and tx_done for every clock.
// Optional feature macro: UART_TX_PARITY_EN (bench follows the same build).
module tb_uart_tx_drain;

    localparam int DW = 8;
    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FLEN = NBITS * BD;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rd;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;

    uart_tx_drain #(
        .DATA_WIDTH (DW),
        .BAUD_DIV   (BD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    // environment FIFO contents and scoreboard state
    logic [DW-1:0]    fifo_q[$];
    logic [NBITS-1:0] exp_q[$];
    int               pop_cycles[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               m_pos = -1;
    logic [NBITS-1:0] m_bits = '0;

    // Line bits of one frame, element 0 goes on the wire first.
    function automatic logic [NBITS-1:0] frame_bits(input logic [DW-1:0] d);
        logic [NBITS-1:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) f[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[DW + 1] = ^d;
`endif
        f[NBITS - 1] = 1'b1;
        return f;
    endfunction

    // driver tasks
    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        drive_fifo();
    endtask

    // One clock: predict, sample at negedge, compare, advance model after posedge.
    task automatic step();
        logic [3:0] exp_v;
        logic [3:0] obs_v;
        logic       load;
        load = (m_pos < 0) && reset && (fifo_q.size() != 0);
        if (load) exp_q.push_back(frame_bits(fifo_q[0]));
        if (m_pos < 0) exp_v = {load, 1'b1, 1'b0, 1'b0};
        else           exp_v = {1'b0, m_bits[m_pos / BD], 1'b1, (m_pos == FLEN - 1)};
        @(negedge clk);
        obs_v = {fifo_rd, tx, tx_busy, tx_done};
        n_vec++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL cycle %0d {rd,tx,busy,done}: got %b want %b", cyc, obs_v, exp_v);
        end
        if (obs_v[3] === 1'b1) pop_cycles.push_back(cyc);
        @(posedge clk);
        if (obs_v[3] === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (!reset) begin
            m_pos = -1;
            exp_q.delete();
        end else if (load) begin
            m_bits = exp_q.pop_front();
            m_pos  = 0;
        end else if (m_pos >= 0) begin
            m_pos++;
            if (m_pos == FLEN) m_pos = -1;
        end
        cyc++;
        #1;
        drive_fifo();
    endtask

    task automatic test_reset();
        push(8'h55);
        repeat (5) step();
        n_vec++;
        if (fifo_q.size() != 1) begin
            n_err++;
            $display("FAIL reset_no_pop: fifo depth %0d want 1", fifo_q.size());
        end
        reset = 1'b1;
        pop_cycles.delete();
        repeat (FLEN + 5) step();
        n_vec++;
        if (pop_cycles.size() != 1) begin
            n_err++;
            $display("FAIL reset_release_pops: got %0d want 1", pop_cycles.size());
        end
    endtask

    task automatic test_idle_empty();
        repeat (100) step();
    endtask

    task automatic test_a5();
        pop_cycles.delete();
        push(8'hA5);
        repeat (FLEN + 10) step();
        n_vec++;
        if (pop_cycles.size() != 1) begin
            n_err++;
            $display("FAIL a5_pops: got %0d want 1", pop_cycles.size());
        end
    endtask

    task automatic test_back_to_back();
        pop_cycles.delete();
        push(8'h01);
        push(8'hFF);
        repeat (2 * FLEN + 10) step();
        n_vec++;
        if (pop_cycles.size() != 2) begin
            n_err++;
            $display("FAIL b2b_pops: got %0d want 2", pop_cycles.size());
        end else if (pop_cycles[1] - pop_cycles[0] != BD * NBITS + 1) begin
            n_err++;
            $display("FAIL b2b_period: got %0d want %0d", pop_cycles[1] - pop_cycles[0], BD * NBITS + 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        push(8'h00);
        push(8'h3C);
        repeat (10) step();
        reset = 1'b0;
        repeat (3) step();
        n_vec++;
        if (fifo_q.size() != 1 || fifo_q[0] !== 8'h3C) begin
            n_err++;
            $display("FAIL abort_fifo_left: depth %0d want 1 holding 3c", fifo_q.size());
        end
        reset = 1'b1;
        pop_cycles.delete();
        step();
        n_vec++;
        if (pop_cycles.size() != 1) begin
            n_err++;
            $display("FAIL pop_after_release: got %0d pops want 1", pop_cycles.size());
        end
        repeat (FLEN + 5) step();
    endtask

    task automatic test_parity();
        push(8'h07);
        push(8'h03);
        repeat (2 * FLEN + 10) step();
    endtask

    task automatic test_random();
        int guard;
        repeat (600) begin
            if ($urandom_range(0, 15) == 0) push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                repeat ($urandom_range(1, 2)) step();
                reset = 1'b1;
            end
            step();
        end
        guard = 0;
        while ((fifo_q.size() != 0 || m_pos >= 0) && guard < 40 * FLEN) begin
            step();
            guard++;
        end
        n_vec++;
        if (guard >= 40 * FLEN) begin
            n_err++;
            $display("FAIL random_drain: timeout, depth %0d", fifo_q.size());
        end
        repeat (5) step();
    endtask

    initial begin
        reset = 1'b0;
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_idle_empty();
        test_a5();
        test_back_to_back();
        test_reset_mid_frame();
        test_parity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
